mem_access_initiator: RTL

MEM_ACCESS_INITIATOR -- requirements
Module: mem_access_initiator

---
 rtl/pkg_cpu.sv | 45 ++++
 rtl/mem_access_initiator.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pkg_cpu.sv
// Shared CPU-side memory types: memory port struct, access-size codes, request-size encoding.
// Latency: none (types, constants and pure combinational helpers only).
// Backpressure: not applicable.
package pkg_cpu;

    localparam int MEM_ADDR_W = 16;

    // Width of a single memory beat as seen by the memory model.
    localparam logic ACC_SZ_8  = 1'b0;
    localparam logic ACC_SZ_16 = 1'b1;

    // Requester transfer size encoding.
    localparam logic [1:0] REQ_SIZE_8   = 2'b00;
    localparam logic [1:0] REQ_SIZE_16  = 2'b01;
    localparam logic [1:0] REQ_SIZE_32  = 2'b10;
    localparam logic [1:0] REQ_SIZE_ILL = 2'b11;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] read_addr;
        logic [MEM_ADDR_W-1:0] write_addr;
        logic [15:0]           write_data_in;
        logic                  read_acc_sz;
        logic                  write_acc_sz;
        logic                  write_data_we;
    } tb_mem_inputs;

    // Store data for the first beat: byte and half stores are right-aligned,
    // a word store sends its high half first.
    function automatic logic [15:0] beat0_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            REQ_SIZE_8:  return {8'h00, wdata[7:0]};
            REQ_SIZE_16: return wdata[15:0];
            default:     return wdata[31:16];
        endcase
    endfunction

    // Zero-extended load result for a single-beat access.
    function automatic logic [31:0] load_ext(input logic [1:0] size, input logic [15:0] rdata);
        if (size == REQ_SIZE_8) begin
            return {24'h000000, rdata[7:0]};
        end
        return {16'h0000, rdata};
    endfunction

endpackage

// File: rtl/mem_access_initiator.sv
// Splits 8/16/32-bit CPU load/store requests into 16-bit-wide memory beats.
// Latency: handshake to resp_valid = 2 cycles (8/16-bit), 3 (32-bit), 1 (illegal size).
// Backpressure: req_ready only in IDLE; one transfer in flight, resp has no ready.
module mem_access_initiator
    import pkg_cpu::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              write_clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output tb_mem_inputs      mem_out,
    input  logic [15:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Request fields latched at handshake.
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_lo_q;

    // Registered memory-side drive; holds its value outside beats.
    logic [ADDR_W-1:0] mem_addr_q;
    logic              acc_sz_q;
    logic [15:0]       wr_dat_q;

    logic [15:0]       rd_hi_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;
    logic              beat_we;

    // State register.
    always_ff @(posedge write_clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        beat_we    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = (req_size == REQ_SIZE_ILL) ? RESP : BEAT0;
                end
            end
            BEAT0: begin
                beat_we = wr_q;
                state_d = (size_q == REQ_SIZE_32) ? BEAT1 : RESP;
            end
            BEAT1: begin
                beat_we = wr_q;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, beat address/data setup and load-result assembly.
    always_ff @(posedge write_clk) begin
        if (reset) begin
            wr_q         <= 1'b0;
            size_q       <= REQ_SIZE_8;
            addr_q       <= '0;
            wdata_lo_q   <= '0;
            mem_addr_q   <= '0;
            acc_sz_q     <= ACC_SZ_8;
            wr_dat_q     <= '0;
            rd_hi_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q       <= req_write;
                        size_q     <= req_size;
                        addr_q     <= req_addr;
                        wdata_lo_q <= req_wdata[15:0];
                        if (req_size == REQ_SIZE_ILL) begin
                            // No memory access: straight to an error response.
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            mem_addr_q <= req_addr;
                            acc_sz_q   <= (req_size == REQ_SIZE_8) ? ACC_SZ_8 : ACC_SZ_16;
                            wr_dat_q   <= beat0_wdata(req_size, req_wdata);
                        end
                    end
                end
                BEAT0: begin
                    if (size_q == REQ_SIZE_32) begin
                        // Second half lives two bytes up; address wraps naturally.
                        rd_hi_q    <= mem_rdata;
                        mem_addr_q <= addr_q + ADDR_W'(2);
                        acc_sz_q   <= ACC_SZ_16;
                        wr_dat_q   <= wdata_lo_q;
                    end else begin
                        resp_rdata_q <= wr_q ? 32'h0 : load_ext(size_q, mem_rdata);
                    end
                end
                BEAT1: begin
                    resp_rdata_q <= wr_q ? 32'h0 : {rd_hi_q, mem_rdata};
                end
                RESP: begin
                    resp_err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Memory port drive; write enable is forced low while reset is asserted.
    always_comb begin
        mem_out               = '0;
        mem_out.read_addr     = MEM_ADDR_W'(mem_addr_q);
        mem_out.write_addr    = MEM_ADDR_W'(mem_addr_q);
        mem_out.write_data_in = wr_dat_q;
        mem_out.read_acc_sz   = acc_sz_q;
        mem_out.write_acc_sz  = acc_sz_q;
        mem_out.write_data_we = beat_we & ~reset;
    end

    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
